// File: rtl/sr_pkg.sv
// Shared types and helpers for the SR flip-flop excitation driver.
package sr_pkg;

    localparam int DEPTH_DEFAULT = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRIVE = 2'd1,
        ST_CHECK = 2'd2
    } state_e;

    // SR excitation: returns {s, r} that moves an SR flip-flop from q_m to t.
    function automatic logic [1:0] excite(input logic q_m, input logic t);
        excite = {~q_m & t, q_m & ~t};
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with occupancy count; full and empty derive from the registered count.
module sync_fifo #(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic                   din,
    input  logic                   pop,
    output logic                   dout,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    logic          mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == FULL_CNT);
    assign empty   = (count == '0);
    // A push into a full FIFO is dropped even when a pop frees a slot on the same edge.
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/sr_excite_driver.sv
// Drives an external SR flip-flop toward a queued stream of target bits, one DRIVE/CHECK slot per target.
module sr_excite_driver
    import sr_pkg::*;
#(
    parameter int DEPTH    = DEPTH_DEFAULT,
    parameter bit CHECK_EN = 1'b1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   tgt_valid,
    input  logic                   tgt_bit,
    output logic                   tgt_ready,
    output logic                   s,
    output logic                   r,
    input  logic                   q_fb,
    input  logic                   err_clr,
    output logic                   busy,
    output logic                   err,
    output logic [$clog2(DEPTH):0] count
);

    state_e state;
    logic   q_m;
    logic   fifo_dout;
    logic   fifo_full;
    logic   fifo_empty;
    logic   pop;
    logic   mismatch;

    sync_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (tgt_valid),
        .din   (tgt_bit),
        .pop   (pop),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (count)
    );

    assign tgt_ready = !fifo_full;
    assign busy      = (state != ST_IDLE) || !fifo_empty;
    // A new target can only start from IDLE or at the end of CHECK.
    assign pop       = ((state == ST_IDLE) || (state == ST_CHECK)) && !fifo_empty;
    assign mismatch  = CHECK_EN && (state == ST_CHECK) && (q_fb != q_m);

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= ST_IDLE;
            q_m   <= 1'b0;
            s     <= 1'b0;
            r     <= 1'b0;
            err   <= 1'b0;
        end else begin
            s <= 1'b0;
            r <= 1'b0;
            if (pop) begin
                {s, r} <= excite(q_m, fifo_dout);
                q_m    <= fifo_dout;
                state  <= ST_DRIVE;
            end else if (state == ST_DRIVE) begin
                state <= ST_CHECK;
            end else begin
                state <= ST_IDLE;
            end
            // A mismatch on the clearing edge takes priority so no error is lost.
            if (mismatch)     err <= 1'b1;
            else if (err_clr) err <= 1'b0;
        end
    end

endmodule
